// File: rtl/clock_root_responder.sv
// rtl/clock_root_responder.sv - parent-side clock-tree responder owning the source enable/ack handshake
module clock_root_responder #(
    parameter int NUM_CHILDREN   = 4,
    parameter int START_CYCLES   = 8,
    parameter int STOP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int AW = $clog2(NUM_CHILDREN + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CHILDREN-1:0] child_request,
    output logic                    parent_ready,
    output logic                    parent_silent,
    output logic                    parent_starting,
    output logic                    parent_stopping,
    output logic                    source_enable,
    input  logic                    source_enable_ack,
    output logic [AW-1:0]           active_count,
    output logic                    fault
);

    localparam int MAX_SS = (START_CYCLES > STOP_CYCLES) ? START_CYCLES : STOP_CYCLES;
    localparam int MAX_C  = (MAX_SS > TIMEOUT_CYCLES) ? MAX_SS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAX_C + 1);

    localparam logic [1:0] S_SILENT   = 2'd0;
    localparam logic [1:0] S_STARTING = 2'd1;
    localparam logic [1:0] S_READY    = 2'd2;
    localparam logic [1:0] S_STOPPING = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] settle_q, settle_d;
    logic [CW-1:0] to_q, to_d;
    logic          en_q, en_d;
    logic          fault_q, fault_d;
    logic          ack_meta_q, ack_s_q;
    logic          ready_q, silent_q, starting_q, stopping_q;
    logic [AW-1:0] count_q, count_d;
    logic          any_req;

    assign any_req = |child_request;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            count_d = count_d + AW'(child_request[i]);
        end
    end

    // Settle counter advances only while ack sits at the target level; the timeout
    // counter advances while it does not, and saturates at the fault threshold.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        to_d     = to_q;
        en_d     = en_q;
        fault_d  = fault_q;
        case (state_q)
            S_SILENT: begin
                en_d = 1'b0;
                if (any_req) begin
                    state_d  = S_STARTING;
                    en_d     = 1'b1;
                    settle_d = '0;
                    to_d     = '0;
                end
            end
            S_STARTING: begin
                en_d = 1'b1;
                if (ack_s_q) begin
                    if (settle_q == CW'(START_CYCLES - 1)) begin
                        state_d = S_READY;
                    end else if (settle_q != CW'(MAX_C)) begin
                        settle_d = settle_q + 1'b1;
                    end
                end else if (to_q != CW'(TIMEOUT_CYCLES)) begin
                    to_d = to_q + 1'b1;
                    if (to_q == CW'(TIMEOUT_CYCLES - 1)) fault_d = 1'b1;
                end
            end
            S_READY: begin
                en_d = 1'b1;
                if (!any_req) begin
                    state_d  = S_STOPPING;
                    en_d     = 1'b0;
                    settle_d = '0;
                    to_d     = '0;
                end
            end
            S_STOPPING: begin
                en_d = 1'b0;
                if (!ack_s_q) begin
                    if (settle_q == CW'(STOP_CYCLES - 1)) begin
                        state_d = S_SILENT;
                    end else if (settle_q != CW'(MAX_C)) begin
                        settle_d = settle_q + 1'b1;
                    end
                end else if (to_q != CW'(TIMEOUT_CYCLES)) begin
                    to_d = to_q + 1'b1;
                    if (to_q == CW'(TIMEOUT_CYCLES - 1)) fault_d = 1'b1;
                end
            end
            default: begin
                state_d = S_SILENT;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_SILENT;
            settle_q   <= '0;
            to_q       <= '0;
            en_q       <= 1'b0;
            fault_q    <= 1'b0;
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
            ready_q    <= 1'b0;
            silent_q   <= 1'b1;
            starting_q <= 1'b0;
            stopping_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            to_q       <= to_d;
            en_q       <= en_d;
            fault_q    <= fault_d;
            ack_meta_q <= source_enable_ack;
            ack_s_q    <= ack_meta_q;
            ready_q    <= (state_d == S_READY);
            silent_q   <= (state_d == S_SILENT);
            starting_q <= (state_d == S_STARTING);
            stopping_q <= (state_d == S_STOPPING);
            count_q    <= count_d;
        end
    end

    assign parent_ready    = ready_q;
    assign parent_silent   = silent_q;
    assign parent_starting = starting_q;
    assign parent_stopping = stopping_q;
    assign source_enable   = en_q;
    assign fault           = fault_q;
    assign active_count    = count_q;

endmodule

// File: doc/clock_root_responder.md
# clock_root_responder

Parent-side responder for the clock-tree request/status protocol: serves up to NUM_CHILDREN clock children that each drive a request line, and broadcasts a single one-hot parent status back to them (ready / silent / starting / stopping). It owns the enable/ack handshake to its clock source (oscillator or PLL slice). It powers the source up on the first request and down when the last request drops, with programmable settle times and an ack timeout fault. It sits at a root node of the clock tree, opposite the child-side control logic of each divider module.

## Interface
- NUM_CHILDREN, 4: number of child request inputs (1..32).
- START_CYCLES, 8: settle cycles counted after source ack is seen high before reporting ready (≥1).
- STOP_CYCLES, 4: settle cycles counted after source ack is seen low before reporting silent (≥1).
- TIMEOUT_CYCLES, 64: cycles allowed for the synchronized ack to reach its target level before fault is raised (≥2).
- clock  in  1  block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- child_request  in  NUM_CHILDREN  per-child clock request, level.
- parent_ready  out  1  source running and settled.
- parent_silent  out  1  source off and settled.
- parent_starting  out  1  power-up sequence in progress.
- parent_stopping  out  1  power-down sequence in progress.
- source_enable  out  1  level enable to clock source.
- source_enable_ack  in  1  level ack from clock source; asynchronous, synchronized internally.
- active_count  out  $clog2(NUM_CHILDREN+1)  registered popcount of child_request.
- fault  out  1  sticky ack-timeout flag.

## Operation
- Two-flop synchronizer on source_enable_ack produces ack_s. Reset clears both flops.
- any_req = OR of child_request, sampled raw. Children hold requests as levels.
- FSM states are SILENT, STARTING, READY and STOPPING. The four status outputs are a registered one-hot decode of the state: exactly one is high every cycle.
- SILENT: source_enable=0. If any_req=1, go to STARTING; source_enable=1 from the same edge.
- STARTING: source_enable=1. settle_cnt clears on entry and increments on each edge with ack_s=1. On the edge where ack_s=1 and settle_cnt==START_CYCLES-1, go to READY. The start sequence always completes: requests dropping mid-start do not abort it.
- READY: source_enable=1. If any_req=0, go to STOPPING; source_enable=0 from the same edge.
- STOPPING: source_enable=0. settle_cnt clears on entry and increments on each edge with ack_s=0. On the edge where ack_s=0 and settle_cnt==STOP_CYCLES-1, go to SILENT. The stop sequence always completes. A request arriving mid-stop is served from SILENT on the next edge.
- settle_cnt holds rather than clearing while ack_s is at the wrong level. An ack glitch extends the settle time but does not restart it.
- to_cnt clears on entry to STARTING/STOPPING and increments each edge while ack_s has not yet reached its target level (1 in STARTING, 0 in STOPPING).
  - When to_cnt reaches TIMEOUT_CYCLES, fault is set.
  - fault is cleared only by reset.
  - The state keeps waiting; recovery is by reset.
- active_count updates every edge from child_request; latency 1 cycle.
- Counter widths: $clog2(max(START_CYCLES,STOP_CYCLES,TIMEOUT_CYCLES)+1). Counters saturate and never wrap.

## Timing
- Reset values, with reset high at an edge:
  - State is SILENT.
  - parent_silent=1.
  - parent_ready, parent_starting and parent_stopping are 0.
  - source_enable, fault, active_count, counters and sync flops are 0.
- Reset takes priority over all transitions, including mid-sequence. source_enable drops the cycle after reset is sampled.
- Request sampled at edge 0 in SILENT: parent_starting and source_enable are high after edge 0.
- Source acks before edge 1: ack_s is high after edge 2, counting runs on edges 3..2+START_CYCLES, and parent_ready is high after edge 2+START_CYCLES.
- Last request drops, sampled at edge s in READY: STOPPING begins after edge s. With the ack low before s+1, parent_silent is high after edge s+2+STOP_CYCLES.
- Simultaneous events: requests toggling within one cycle are seen only at edges. A READY→STOPPING decision ignores requests that rise on later edges.

## Test plan
- Reset with child_request=4'b0011 held: all outputs at reset values during reset. After release, parent_starting=1 and source_enable=1 one edge later.
- Ack model with 1-cycle response, START=8, STOP=4:
  - Request at edge 0 gives parent_ready after edge 10.
  - All requests dropped at edge 20 give parent_stopping after edge 20 and parent_silent after edge 26.
- Request dropped at edge 4 (mid-start): parent_ready still asserts after edge 10, then STOPPING begins after edge 11.
- Request raised during STOPPING: parent_silent is high for exactly one cycle, then parent_starting, and source_enable reasserts.
- Ack tied low: fault=1 TIMEOUT_CYCLES edges after entering STARTING. The state stays STARTING and fault stays 1 until reset.
- child_request=4'b1011: active_count=3 one cycle later. An ack glitch (ack low for 1 cycle) during STARTING delays parent_ready by exactly 1 cycle.
